hp_bar_animator: RTL and testbench
==================================

// Module: hp_bar_animator
// PURPOSE
//  Parametrised HP-bar engine for the fight scene: N_CH independent bars whose displayed HP
//  walks toward a target HP at a fixed frame-paced rate (the hpReducing animation), plus the
//  per-pixel bar/track overlay and colour for the VGA mux. Sits between the battle FSM
//  (targets, done handshakes) and the scene pixel mux (in_bar, bar_rgb).
// PARAMETERS
//  N_CH       2    number of bars/channels
//  HP_W       8    HP width; displayed HP in pixels is the bar length (1 HP = 1 px)
//  STEP       1    HP moved per animation step
//  FRAME_DIV  2    frame_start pulses per animation step (1..15)
//  BAR_V_LEN  10   bar height in lines
//  CNT_W      10   h_cnt/v_cnt width
// PORTS
//  clk          in   1           pixel/system clock
//  rst_n        in   1           asynchronous active-low reset
//  h_cnt        in   CNT_W       current pixel column
//  v_cnt        in   CNT_W       current pixel line
//  frame_start  in   1           one-cycle pulse at start of each frame (vsync edge)
//  hp_max       in   N_CH*HP_W   per-channel max HP (track length), chan i at [i*HP_W +: HP_W]
//  hp_target    in   N_CH*HP_W   per-channel target HP
//  hp_load      in   N_CH        pulse: snap displayed HP to target, no animation
//  bar_h_start  in   N_CH*CNT_W  bar left column per channel
//  bar_v_start  in   N_CH*CNT_W  bar top line per channel
//  busy         out  N_CH        channel animating
//  done         out  N_CH        one-cycle pulse when displayed reaches target after animating
//  in_bar       out  1           registered: pixel inside any channel's track
//  bar_rgb      out  12          registered colour for that pixel (12'h000 when !in_bar)
// BEHAVIOUR
//  Reset: displayed HP=0, frame counters=0, busy=0, done=0, in_bar=0, bar_rgb=12'h000; state IDLE.
//  Per-channel FSM: IDLE -> DEC (target<shown) | INC (target>shown), evaluated every cycle.
//   DEC/INC: on the frame_start that makes frame_cnt==FRAME_DIV-1, shown moves STEP toward target,
//   clamped so it never overshoots; frame_cnt wraps to 0. On reaching target -> IDLE, done=1 one cycle.
//  busy = (state!=IDLE). Target retargeted mid-animation: direction re-evaluated next cycle, no done
//   pulse unless target reached; direction reversal goes DEC<->INC directly.
//  hp_load has priority over stepping: shown<=target same cycle, state IDLE, frame_cnt=0, no done.
//  target>hp_max: target clamped to hp_max before use. hp_max==0: track empty, in_bar never set.
//  Entering DEC/INC from IDLE resets frame_cnt=0 (first step after FRAME_DIV frames).
//  Pixel path (1-cycle latency from h_cnt/v_cnt): channel i hit when
//   h_start<=h_cnt<h_start+hp_max and v_start<=v_cnt<v_start+BAR_V_LEN (unsigned, CNT_W+1-bit sums).
//   Within hit: column offset < shown -> fill colour, else track 12'h888.
//   Fill: 4*shown >= 2*hp_max -> 12'h0f0; 4*shown >= hp_max -> 12'hfd0; else 12'hf00 (HP_W+2-bit math).
//   Overlapping channels: lowest index wins.
//  Reset asserted mid-animation: immediate return to reset values; no done pulse.
// STRUCTURE
//  Shared package/header: colour constants (COL_HP_HIGH/MID/LOW/TRACK), FSM encodings IDLE/DEC/INC.
//  Sub-module hp_bar_channel (FSM, frame counter, shown register, hit/fill compare) instantiated
//  N_CH times via generate; top does priority mux and output registers.
// TESTING
//  1 max=100, load 100, target 60, FRAME_DIV=2 -> busy 1, shown -1 every 2nd frame_start, done
//    pulse once after 80 frame_starts, shown=60, fill 12'h0f0 throughout (60*4>=200).
//  2 max=100, shown 30, target 20 -> colour 12'hfd0 until shown 24, then 12'hf00; track 12'h888
//    at offsets >=shown up to 99.
//  3 STEP=7, shown 10, target 0 -> steps 10,3,0 (clamped), done after 2 steps.
//  4 shown 80 DEC to 40, at shown 60 target set 90 -> INC, no done until 90, one done pulse.
//  5 hp_load mid-animation target 55 -> shown=55 next cycle, busy=0, no done; target 200 with
//    max 100 -> clamped to 100.
//  6 two channels overlapping region -> ch0 colour; rst_n low mid-DEC -> all outputs 0 async.

Source files
------------

// File: rtl/hp_bar_animator_pkg.sv
// rtl/hp_bar_animator_pkg.sv - shared colours and channel FSM encoding for the HP-bar engine
package hp_bar_animator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        INC  = 2'd2
    } hp_state_t;

    localparam logic [11:0] COL_HP_HIGH = 12'h0f0;
    localparam logic [11:0] COL_HP_MID  = 12'hfd0;
    localparam logic [11:0] COL_HP_LOW  = 12'hf00;
    localparam logic [11:0] COL_TRACK   = 12'h888;
    localparam logic [11:0] COL_NONE    = 12'h000;

endpackage

// File: rtl/hp_bar_animator_if.sv
// rtl/hp_bar_animator_if.sv - battle-FSM / pixel-mux side signals of the HP-bar engine
interface hp_bar_animator_if #(
    parameter int N_CH  = 2,
    parameter int HP_W  = 8,
    parameter int CNT_W = 10
);
    logic [CNT_W-1:0]      h_cnt;
    logic [CNT_W-1:0]      v_cnt;
    logic                  frame_start;
    logic [N_CH*HP_W-1:0]  hp_max;
    logic [N_CH*HP_W-1:0]  hp_target;
    logic [N_CH-1:0]       hp_load;
    logic [N_CH*CNT_W-1:0] bar_h_start;
    logic [N_CH*CNT_W-1:0] bar_v_start;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       done;
    logic                  in_bar;
    logic [11:0]           bar_rgb;

    modport master (
        output h_cnt, v_cnt, frame_start, hp_max, hp_target, hp_load, bar_h_start, bar_v_start,
        input  busy, done, in_bar, bar_rgb
    );

    modport slave (
        input  h_cnt, v_cnt, frame_start, hp_max, hp_target, hp_load, bar_h_start, bar_v_start,
        output busy, done, in_bar, bar_rgb
    );
endinterface

// File: rtl/hp_bar_channel.sv
// rtl/hp_bar_channel.sv - one bar: frame-paced walk of displayed HP toward target, plus pixel hit/colour
module hp_bar_channel
    import hp_bar_animator_pkg::*;
#(
    parameter int HP_W      = 8,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 2,
    parameter int BAR_V_LEN = 10,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start_i,
    input  logic [HP_W-1:0]  hp_max_i,
    input  logic [HP_W-1:0]  hp_target_i,
    input  logic             hp_load_i,
    input  logic [CNT_W-1:0] h_cnt_i,
    input  logic [CNT_W-1:0] v_cnt_i,
    input  logic [CNT_W-1:0] h_start_i,
    input  logic [CNT_W-1:0] v_start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             hit_o,
    output logic [11:0]      rgb_o
);
    localparam logic [HP_W-1:0] STEP_V   = HP_W'(STEP);
    localparam logic [3:0]      DIV_LAST = 4'(FRAME_DIV - 1);

    hp_state_t       state_q, state_d;
    logic [HP_W-1:0] shown_q, shown_d;
    logic [3:0]      fcnt_q, fcnt_d;
    logic            done_q, done_d;

    logic [HP_W-1:0] tgt;
    logic [HP_W-1:0] gap;
    logic [HP_W-1:0] stepped;

    assign tgt = (hp_target_i > hp_max_i) ? hp_max_i : hp_target_i;

    // One step toward target, landing exactly on it when closer than STEP.
    always_comb begin
        gap = (tgt < shown_q) ? (shown_q - tgt) : (tgt - shown_q);
        if (gap <= STEP_V)
            stepped = tgt;
        else if (tgt < shown_q)
            stepped = shown_q - STEP_V;
        else
            stepped = shown_q + STEP_V;
    end

    always_comb begin
        state_d = state_q;
        shown_d = shown_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;
        if (hp_load_i) begin
            shown_d = tgt;
            state_d = IDLE;
            fcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tgt != shown_q) begin
                        state_d = (tgt < shown_q) ? DEC : INC;
                        fcnt_d  = '0;
                    end
                end
                DEC, INC: begin
                    if (tgt == shown_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = (tgt < shown_q) ? DEC : INC;
                        if (frame_start_i) begin
                            if (fcnt_q == DIV_LAST) begin
                                fcnt_d  = '0;
                                shown_d = stepped;
                                if (stepped == tgt) begin
                                    state_d = IDLE;
                                    done_d  = 1'b1;
                                end
                            end else begin
                                fcnt_d = fcnt_q + 4'd1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shown_q <= '0;
            fcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shown_q <= shown_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

    // Window ends are one bit wider so a bar near the right/bottom edge cannot wrap.
    logic [CNT_W:0]   h_end;
    logic [CNT_W:0]   v_end;
    logic [CNT_W-1:0] col_off;
    logic [HP_W+1:0]  shown_x4;
    logic [HP_W+1:0]  max_x2;
    logic [HP_W+1:0]  max_x1;
    logic [11:0]      fill_rgb;

    assign h_end   = {1'b0, h_start_i} + (CNT_W+1)'(hp_max_i);
    assign v_end   = {1'b0, v_start_i} + (CNT_W+1)'(BAR_V_LEN);
    assign hit_o   = (h_cnt_i >= h_start_i) && ({1'b0, h_cnt_i} < h_end) &&
                     (v_cnt_i >= v_start_i) && ({1'b0, v_cnt_i} < v_end);
    assign col_off = h_cnt_i - h_start_i;

    assign shown_x4 = {shown_q, 2'b00};
    assign max_x2   = {1'b0, hp_max_i, 1'b0};
    assign max_x1   = {2'b00, hp_max_i};

    always_comb begin
        if (shown_x4 >= max_x2)
            fill_rgb = COL_HP_HIGH;
        else if (shown_x4 >= max_x1)
            fill_rgb = COL_HP_MID;
        else
            fill_rgb = COL_HP_LOW;
    end

    assign rgb_o = (col_off < CNT_W'(shown_q)) ? fill_rgb : COL_TRACK;

endmodule

// File: rtl/hp_bar_animator.sv
// rtl/hp_bar_animator.sv - N_CH animated HP bars with a registered, lowest-index-wins pixel overlay
module hp_bar_animator
    import hp_bar_animator_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int HP_W      = 8,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 2,
    parameter int BAR_V_LEN = 10,
    parameter int CNT_W     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    hp_bar_animator_if.slave bus
);
    logic [N_CH-1:0] ch_busy;
    logic [N_CH-1:0] ch_done;
    logic [N_CH-1:0] ch_hit;
    logic [11:0]     ch_rgb [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            hp_bar_channel #(
                .HP_W      (HP_W),
                .STEP      (STEP),
                .FRAME_DIV (FRAME_DIV),
                .BAR_V_LEN (BAR_V_LEN),
                .CNT_W     (CNT_W)
            ) u_ch (
                .clk           (clk),
                .rst_n         (rst_n),
                .frame_start_i (bus.frame_start),
                .hp_max_i      (bus.hp_max[gi*HP_W +: HP_W]),
                .hp_target_i   (bus.hp_target[gi*HP_W +: HP_W]),
                .hp_load_i     (bus.hp_load[gi]),
                .h_cnt_i       (bus.h_cnt),
                .v_cnt_i       (bus.v_cnt),
                .h_start_i     (bus.bar_h_start[gi*CNT_W +: CNT_W]),
                .v_start_i     (bus.bar_v_start[gi*CNT_W +: CNT_W]),
                .busy_o        (ch_busy[gi]),
                .done_o        (ch_done[gi]),
                .hit_o         (ch_hit[gi]),
                .rgb_o         (ch_rgb[gi])
            );
        end
    endgenerate

    logic        in_bar_q, in_bar_d;
    logic [11:0] bar_rgb_q, bar_rgb_d;

    // Scan from the top index down so the lowest hit channel is the last writer.
    always_comb begin
        in_bar_d  = 1'b0;
        bar_rgb_d = COL_NONE;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_hit[i]) begin
                in_bar_d  = 1'b1;
                bar_rgb_d = ch_rgb[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_bar_q  <= 1'b0;
            bar_rgb_q <= COL_NONE;
        end else begin
            in_bar_q  <= in_bar_d;
            bar_rgb_q <= bar_rgb_d;
        end
    end

    assign bus.busy    = ch_busy;
    assign bus.done    = ch_done;
    assign bus.in_bar  = in_bar_q;
    assign bus.bar_rgb = bar_rgb_q;

endmodule

// File: tb/tb_hp_bar_animator.sv
// tb/tb_hp_bar_animator.sv - scoreboard bench for hp_bar_animator (STEP=1 and STEP=7 instances)
module tb_hp_bar_animator;
    localparam int HW = 8;
    localparam int CW = 10;
    localparam int FD = 2;
    localparam int VL = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hp_bar_animator_if #(.N_CH(2), .HP_W(HW), .CNT_W(CW)) bif ();
    hp_bar_animator_if #(.N_CH(2), .HP_W(HW), .CNT_W(CW)) bif7 ();

    hp_bar_animator #(.N_CH(2), .HP_W(HW), .STEP(1), .FRAME_DIV(FD), .BAR_V_LEN(VL), .CNT_W(CW))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(bif));
    hp_bar_animator #(.N_CH(2), .HP_W(HW), .STEP(7), .FRAME_DIV(FD), .BAR_V_LEN(VL), .CNT_W(CW))
        u_dut7 (.clk(clk), .rst_n(rst_n), .bus(bif7));

    int m_max [2][2];
    int m_tgt [2][2];
    int m_shown [2][2];
    int m_fc [2][2];
    int m_hs [2][2];
    int m_vs [2][2];
    int exp_done [2][2];
    int done_cnt [2][2];
    int vectors = 0;
    int miscompares = 0;
    logic [12:0] sb_q [$];

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (bif.done[c] === 1'b1) done_cnt[0][c]++;
            if (bif7.done[c] === 1'b1) done_cnt[1][c]++;
        end
    end

    function automatic int clampt(input int d, input int c);
        return (m_tgt[d][c] > m_max[d][c]) ? m_max[d][c] : m_tgt[d][c];
    endfunction

    function automatic logic [11:0] fill_col(input int s, input int mx);
        if (4 * s >= 2 * mx) return 12'h0f0;
        if (4 * s >= mx) return 12'hfd0;
        return 12'hf00;
    endfunction

    function automatic logic [12:0] model_pix(input int d, input int h, input int v);
        logic [12:0] r;
        r = 13'h0;
        for (int c = 1; c >= 0; c--) begin
            if (h >= m_hs[d][c] && h < m_hs[d][c] + m_max[d][c] &&
                v >= m_vs[d][c] && v < m_vs[d][c] + VL)
                r = {1'b1, (h - m_hs[d][c] < m_shown[d][c]) ?
                           fill_col(m_shown[d][c], m_max[d][c]) : 12'h888};
        end
        return r;
    endfunction

    task automatic cfg(input int d, input int c, input int hs, input int vs, input int mx);
        @(negedge clk);
        if (d == 0) begin
            bif.bar_h_start[c*CW +: CW] = CW'(hs);
            bif.bar_v_start[c*CW +: CW] = CW'(vs);
            bif.hp_max[c*HW +: HW]      = HW'(mx);
        end else begin
            bif7.bar_h_start[c*CW +: CW] = CW'(hs);
            bif7.bar_v_start[c*CW +: CW] = CW'(vs);
            bif7.hp_max[c*HW +: HW]      = HW'(mx);
        end
        m_hs[d][c] = hs;
        m_vs[d][c] = vs;
        m_max[d][c] = mx;
    endtask

    task automatic set_tgt(input int d, input int c, input int t, input logic ld);
        bit was_idle;
        @(negedge clk);
        was_idle = (m_shown[d][c] == clampt(d, c));
        if (d == 0) begin
            bif.hp_target[c*HW +: HW] = HW'(t);
            bif.hp_load[c] = ld;
        end else begin
            bif7.hp_target[c*HW +: HW] = HW'(t);
            bif7.hp_load[c] = ld;
        end
        m_tgt[d][c] = t;
        if (ld) begin
            m_shown[d][c] = clampt(d, c);
            m_fc[d][c] = 0;
        end else if (was_idle) begin
            m_fc[d][c] = 0;
        end
        @(negedge clk);
        if (d == 0) bif.hp_load[c] = 1'b0;
        else bif7.hp_load[c] = 1'b0;
    endtask

    task automatic frame(input int d);
        int t;
        int stp;
        stp = (d == 0) ? 1 : 7;
        @(negedge clk);
        if (d == 0) bif.frame_start = 1'b1; else bif7.frame_start = 1'b1;
        @(negedge clk);
        if (d == 0) bif.frame_start = 1'b0; else bif7.frame_start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            t = clampt(d, c);
            if (m_shown[d][c] != t) begin
                m_fc[d][c]++;
                if (m_fc[d][c] == FD) begin
                    m_fc[d][c] = 0;
                    if (m_shown[d][c] > t)
                        m_shown[d][c] = (m_shown[d][c] - t <= stp) ? t : m_shown[d][c] - stp;
                    else
                        m_shown[d][c] = (t - m_shown[d][c] <= stp) ? t : m_shown[d][c] + stp;
                    if (m_shown[d][c] == t) exp_done[d][c]++;
                end
            end
        end
    endtask

    task automatic probe(input int d, input int h, input int v, input string name);
        logic [12:0] exp_v;
        logic [12:0] got;
        @(negedge clk);
        if (d == 0) begin bif.h_cnt = CW'(h); bif.v_cnt = CW'(v); end
        else begin bif7.h_cnt = CW'(h); bif7.v_cnt = CW'(v); end
        sb_q.push_back(model_pix(d, h, v));
        @(negedge clk);
        exp_v = sb_q.pop_front();
        got = (d == 0) ? {bif.in_bar, bif.bar_rgb} : {bif7.in_bar, bif7.bar_rgb};
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL %s dut%0d h=%0d v=%0d got in_bar/rgb=%h required=%h", name, d, h, v, got, exp_v);
        end
    endtask

    task automatic check_busy(input int d, input string name);
        logic [1:0] got;
        logic [1:0] exp_v;
        got = (d == 0) ? bif.busy : bif7.busy;
        for (int c = 0; c < 2; c++) exp_v[c] = (m_shown[d][c] != clampt(d, c));
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL %s dut%0d busy got %b required %b", name, d, got, exp_v);
        end
    endtask

    task automatic check_done(input int d, input string name);
        @(negedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if (done_cnt[d][c] !== exp_done[d][c]) begin
                miscompares++;
                $display("FAIL %s dut%0d ch%0d done pulses got %0d required %0d",
                         name, d, c, done_cnt[d][c], exp_done[d][c]);
            end
        end
    endtask

    task automatic check_zero(input int d, input string name);
        logic [15:0] got;
        got = (d == 0) ? {bif.busy, bif.done, bif.in_bar, bif.bar_rgb[11:0], 1'b0}
                       : {bif7.busy, bif7.done, bif7.in_bar, bif7.bar_rgb[11:0], 1'b0};
        vectors++;
        if (got !== 16'h0) begin
            miscompares++;
            $display("FAIL %s dut%0d busy/done/in_bar/rgb got %h required 0", name, d, got);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_zero(0, "reset_state");
        check_zero(1, "reset_state");
        cfg(0, 0, 100, 50, 100);
        cfg(1, 0, 100, 50, 100);
        @(negedge clk);
        rst_n = 1'b1;
        probe(0, 100, 50, "reset_shown_zero");
        probe(1, 100, 59, "reset_shown_zero");
        check_busy(0, "reset_idle");
    endtask

    task automatic test_dec_high();
        set_tgt(0, 0, 100, 1'b1);
        set_tgt(0, 0, 60, 1'b0);
        check_busy(0, "dec_start_busy");
        for (int k = 0; k < 80; k++) begin
            frame(0);
            check_busy(0, "dec_busy");
            probe(0, 100 + m_shown[0][0] - 1, 55, "dec_fill");
            probe(0, 100 + m_shown[0][0], 55, "dec_edge");
        end
        check_done(0, "dec_done_once");
    endtask

    task automatic test_colour();
        set_tgt(0, 0, 30, 1'b1);
        set_tgt(0, 0, 20, 1'b0);
        probe(0, 99, 55, "left_edge_miss");
        probe(0, 199, 55, "track_last_col");
        probe(0, 200, 55, "right_edge_miss");
        probe(0, 150, 49, "top_edge_miss");
        probe(0, 150, 59, "bottom_row_hit");
        probe(0, 150, 60, "bottom_edge_miss");
        for (int k = 0; k < 20; k++) begin
            frame(0);
            probe(0, 100, 52, "colour_off0");
            probe(0, 100 + m_shown[0][0] - 1, 52, "colour_fill");
            probe(0, 100 + m_shown[0][0], 52, "colour_track");
        end
        check_done(0, "colour_done");
    endtask

    task automatic test_step7();
        set_tgt(1, 0, 10, 1'b1);
        set_tgt(1, 0, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            frame(1);
            check_busy(1, "step7_busy");
            probe(1, 100, 55, "step7_off0");
            probe(1, 102, 55, "step7_off2");
            probe(1, 103, 55, "step7_off3");
            probe(1, 109, 55, "step7_off9");
        end
        check_done(1, "step7_done");
    endtask

    task automatic test_reverse();
        int k;
        set_tgt(0, 0, 80, 1'b1);
        set_tgt(0, 0, 40, 1'b0);
        k = 0;
        while (m_shown[0][0] != 60 && k < 200) begin frame(0); k++; end
        set_tgt(0, 0, 90, 1'b0);
        check_busy(0, "reverse_busy");
        k = 0;
        while (m_shown[0][0] != 90 && k < 200) begin
            frame(0);
            k++;
            if (k % 10 == 0) begin
                check_done(0, "reverse_no_early_done");
                probe(0, 100 + m_shown[0][0] - 1, 55, "reverse_fill");
                probe(0, 100 + m_shown[0][0], 55, "reverse_edge");
            end
        end
        vectors++;
        if (k >= 200) begin
            miscompares++;
            $display("FAIL reverse_timeout frames=%0d required<200", k);
        end
        check_done(0, "reverse_done");
        check_busy(0, "reverse_idle");
        probe(0, 189, 55, "reverse_final");
    endtask

    task automatic test_load();
        set_tgt(0, 0, 80, 1'b1);
        set_tgt(0, 0, 40, 1'b0);
        repeat (5) frame(0);
        set_tgt(0, 0, 55, 1'b1);
        check_busy(0, "load_not_busy");
        check_done(0, "load_no_done");
        probe(0, 154, 55, "load_fill");
        probe(0, 155, 55, "load_track");
        set_tgt(0, 0, 200, 1'b1);
        probe(0, 199, 55, "clamp_fill");
        check_busy(0, "clamp_idle");
        set_tgt(0, 0, 90, 1'b0);
        repeat (20) frame(0);
        check_busy(0, "clamp_walk_idle");
        probe(0, 189, 55, "clamp_walk_fill");
        probe(0, 190, 55, "clamp_walk_track");
        check_done(0, "clamp_walk_done");
    endtask

    task automatic test_overlap_reset();
        cfg(0, 0, 10, 20, 100);
        cfg(0, 1, 50, 25, 100);
        set_tgt(0, 0, 100, 1'b1);
        set_tgt(0, 1, 20, 1'b1);
        probe(0, 60, 26, "overlap_ch0_wins");
        probe(0, 60, 32, "ch1_fill");
        probe(0, 75, 32, "ch1_track");
        probe(0, 60, 22, "ch0_only");
        cfg(0, 1, 50, 25, 0);
        probe(0, 50, 32, "max0_no_bar");
        set_tgt(0, 0, 40, 1'b0);
        repeat (3) frame(0);
        probe(0, 15, 22, "pre_reset_bar");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero(0, "async_reset");
        check_zero(1, "async_reset");
        bif.hp_target = '0;
        bif7.hp_target = '0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                m_tgt[d][c] = 0;
                m_shown[d][c] = 0;
                m_fc[d][c] = 0;
            end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_busy(0, "post_reset_idle");
        check_done(0, "reset_no_done");
        probe(0, 15, 22, "post_reset_track");
    endtask

    initial begin
        bif.h_cnt = '0; bif.v_cnt = '0; bif.frame_start = 1'b0;
        bif.hp_max = '0; bif.hp_target = '0; bif.hp_load = '0;
        bif.bar_h_start = '0; bif.bar_v_start = '0;
        bif7.h_cnt = '0; bif7.v_cnt = '0; bif7.frame_start = 1'b0;
        bif7.hp_max = '0; bif7.hp_target = '0; bif7.hp_load = '0;
        bif7.bar_h_start = '0; bif7.bar_v_start = '0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                m_max[d][c] = 0; m_tgt[d][c] = 0; m_shown[d][c] = 0; m_fc[d][c] = 0;
                m_hs[d][c] = 0; m_vs[d][c] = 0; exp_done[d][c] = 0; done_cnt[d][c] = 0;
            end
        test_reset();
        test_dec_high();
        test_colour();
        test_step7();
        test_reverse();
        test_load();
        test_overlap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
